// File: rtl/afpm_host_link.sv
// Host-side initiator for the byte-serial log FP16 multiplier link: serialises an
// operand pair, reassembles the 2-byte result. Optional: AFPM_HOST_ZERO_SHORTCUT_EN.
module afpm_host_link #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic [7:0]  link_a_byte,
  output logic [7:0]  link_b_byte,
  output logic        link_valid,
  input  logic [7:0]  link_res_byte,
  input  logic        link_res_valid
);

  typedef enum logic [2:0] {IDLE, SEND_LO, SEND_HI, WAIT_LO, WAIT_HI, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] a_hi, b_hi;
  logic [7:0] cnt;
  logic       send_q;
  logic       timeout;
  logic       zero_op;

`ifdef AFPM_HOST_ZERO_SHORTCUT_EN
  assign zero_op = (op_a[14:0] == 15'd0) || (op_b[14:0] == 15'd0);
`else
  assign zero_op = 1'b0;
`endif

  // Strobe is suppressed while frozen so the held byte is re-sent once ena returns.
  assign link_valid = send_q & ena;

  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    case (state)
      IDLE:    if (req_valid) state_nx = zero_op ? DONE : SEND_LO;
      SEND_LO: state_nx = SEND_HI;
      SEND_HI: state_nx = WAIT_LO;
      // A low byte landing on the terminal count pushes WAIT_HI past it; >= still expires.
      WAIT_LO: begin
        if (link_res_valid)       state_nx = WAIT_HI;
        else if (cnt >= CNT_LAST) begin timeout = 1'b1; state_nx = DONE; end
      end
      WAIT_HI: begin
        if (link_res_valid)       state_nx = DONE;
        else if (cnt >= CNT_LAST) begin timeout = 1'b1; state_nx = DONE; end
      end
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= 16'd0;
      rsp_error   <= 1'b0;
      link_a_byte <= 8'd0;
      link_b_byte <= 8'd0;
      send_q      <= 1'b0;
      a_hi        <= 8'd0;
      b_hi        <= 8'd0;
      cnt         <= 8'd0;
    end else if (ena) begin
      state     <= state_nx;
      req_ready <= (state_nx == IDLE);
      rsp_valid <= (state_nx == DONE);
      send_q    <= (state_nx == SEND_LO) || (state_nx == SEND_HI);
      case (state)
        IDLE: if (req_valid) begin
          a_hi <= op_a[15:8];
          b_hi <= op_b[15:8];
          if (zero_op) begin
            rsp_data  <= {op_a[15] ^ op_b[15], 15'd0};
            rsp_error <= 1'b0;
          end else begin
            link_a_byte <= op_a[7:0];
            link_b_byte <= op_b[7:0];
          end
        end
        SEND_LO: begin
          link_a_byte <= a_hi;
          link_b_byte <= b_hi;
        end
        SEND_HI: cnt <= 8'd0;
        WAIT_LO: begin
          cnt <= cnt + 8'd1;
          if (link_res_valid) rsp_data[7:0] <= link_res_byte;
          else if (timeout) begin
            rsp_data  <= 16'd0;
            rsp_error <= 1'b1;
          end
        end
        WAIT_HI: begin
          cnt <= cnt + 8'd1;
          if (link_res_valid) rsp_data[15:8] <= link_res_byte;
          else if (timeout) begin
            rsp_data  <= 16'd0;
            rsp_error <= 1'b1;
          end
        end
        DONE: if (rsp_ready) rsp_error <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
